// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text-RAM writer.
// No logic here: geometry defaults, control codes, cell layout and FSM states.
package vga_text_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 25;

  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_TAB = 8'h09;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_CR  = 8'h0D;

  localparam logic [15:0] BLANK_CELL = 16'h0720;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL,
    ST_FILL,
    ST_CLEAR
  } state_t;

  // attr[6:4] background RGB, attr[2:0] foreground RGB
  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
  } cell_t;

  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col,
                                            input int cols);
    return 12'(int'(row) * cols + int'(col));
  endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Cursor register for the text writer: one command per cycle, updates on the next edge.
// scroll_o flags that the command in flight pushes the cursor past the last row.
module vga_text_cursor
  import vga_text_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       adv_i,
  input  logic       lf_i,
  input  logic       cr_i,
  input  logic       bs_i,
  input  logic       home_i,
  output logic [6:0] col_o,
  output logic [4:0] row_o,
  output logic       scroll_o
);

  localparam logic [6:0] COL_MAX = 7'(COLS - 1);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (home_i) begin
      col_d = '0;
      row_d = '0;
    end else if (cr_i) begin
      col_d = '0;
    end else if (lf_i) begin
      col_d = '0;
      if (row_q != ROW_MAX) row_d = row_q + 5'd1;
    end else if (bs_i) begin
      if (col_q != '0) begin
        col_d = col_q - 7'd1;
      end else if (row_q != '0) begin
        col_d = COL_MAX;
        row_d = row_q - 5'd1;
      end
    end else if (adv_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q != ROW_MAX) row_d = row_q + 5'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Row stays pinned at the bottom; the writer scrolls the RAM instead.
  assign scroll_o = (row_q == ROW_MAX) && (lf_i || (adv_i && (col_q == COL_MAX)));
  assign col_o    = col_q;
  assign row_o    = row_q;

endmodule

// File: rtl/vga_text_writer.sv
// Text-RAM write engine: char stream in (valid/ready), cell writes one cycle after accept; scroll/clear hold off char_ready.
// Optional VGA_TEXT_WRITER_TAB_EN: 0x09 pads with spaces to the next 8-column stop instead of printing a glyph.
module vga_text_writer
  import vga_text_pkg::*;
#(
  parameter int          COLS       = COLS_DEF,
  parameter int          ROWS       = ROWS_DEF,
  parameter logic [15:0] BLANK_CELL = vga_text_pkg::BLANK_CELL
) (
  input  logic        pixel_clk,
  input  logic        data_reset,
  input  logic [7:0]  char_in,
  input  logic [7:0]  attr_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic        clear_req,
  output logic [11:0] ram_wr_addr,
  output logic [15:0] ram_wr_data,
  output logic        ram_wr_en,
  output logic [11:0] ram_rd_addr,
  input  logic [15:0] ram_rd_data,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

`ifdef VGA_TEXT_WRITER_TAB_EN
  localparam bit TAB_EN = 1'b1;
`else
  localparam bit TAB_EN = 1'b0;
`endif

  localparam logic [11:0] LAST_ADDR  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] FILL_BASE  = 12'((ROWS - 1) * COLS);
  localparam logic [11:0] ROW_STRIDE = 12'(COLS);

  state_t      state_q;
  logic        busy_q;
  logic        wr_en_q;
  logic [11:0] wr_addr_q;
  cell_t       wr_data_q;
  logic [11:0] rd_addr_q;
  logic [11:0] pend_addr_q;
  logic        rd_run_q;
  logic        pend_vld_q;
  logic        tab_q;

  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        scroll_needed;
  logic        accept;
  logic        is_tab;
  logic        is_glyph;
  logic        tab_more;
  logic [11:0] cur_addr;

  assign accept   = (state_q == ST_IDLE) && !clear_req && char_valid;
  assign is_tab   = TAB_EN && (char_in == CHR_TAB);
  assign is_glyph = !(char_in inside {CHR_BS, CHR_LF, CHR_CR}) && !is_tab;
  // Another pad space is due unless the column just written ends a tab stop or the row.
  assign tab_more = tab_q && (cur_col[2:0] != 3'd7) && (cur_col != 7'(COLS - 1));
  assign cur_addr = cell_addr(cur_row, cur_col, COLS);

  vga_text_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk_i   (pixel_clk),
    .rst_i   (data_reset),
    .adv_i   (state_q == ST_WRITE),
    .lf_i    (accept && (char_in == CHR_LF)),
    .cr_i    (accept && (char_in == CHR_CR)),
    .bs_i    (accept && (char_in == CHR_BS)),
    .home_i  ((state_q == ST_IDLE) && clear_req),
    .col_o   (cur_col),
    .row_o   (cur_row),
    .scroll_o(scroll_needed)
  );

  always_ff @(posedge pixel_clk) begin
    if (data_reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      pend_addr_q <= '0;
      rd_run_q    <= 1'b0;
      pend_vld_q  <= 1'b0;
      tab_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_en_q <= 1'b0;
          if (clear_req) begin
            state_q   <= ST_CLEAR;
            busy_q    <= 1'b1;
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= BLANK_CELL;
          end else if (char_valid) begin
            if (is_glyph || is_tab) begin
              state_q   <= ST_WRITE;
              busy_q    <= 1'b1;
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr;
              wr_data_q <= is_tab ? {attr_in, BLANK_CELL[7:0]} : {attr_in, char_in};
              tab_q     <= is_tab;
            end else if ((char_in == CHR_LF) && scroll_needed) begin
              state_q    <= ST_SCROLL;
              busy_q     <= 1'b1;
              rd_addr_q  <= ROW_STRIDE;
              rd_run_q   <= 1'b1;
              pend_vld_q <= 1'b0;
            end
          end
        end

        ST_WRITE: begin
          if (tab_more) begin
            wr_addr_q <= wr_addr_q + 12'd1;
          end else begin
            wr_en_q <= 1'b0;
            tab_q   <= 1'b0;
            if (scroll_needed) begin
              state_q    <= ST_SCROLL;
              rd_addr_q  <= ROW_STRIDE;
              rd_run_q   <= 1'b1;
              pend_vld_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        // Read address this cycle, data returns next cycle, write-back registered the cycle after.
        ST_SCROLL: begin
          pend_vld_q  <= rd_run_q;
          pend_addr_q <= rd_addr_q;
          if (rd_run_q) begin
            if (rd_addr_q == LAST_ADDR) rd_run_q <= 1'b0;
            else                        rd_addr_q <= rd_addr_q + 12'd1;
          end
          wr_en_q <= pend_vld_q;
          if (pend_vld_q) begin
            wr_addr_q <= pend_addr_q - ROW_STRIDE;
            wr_data_q <= ram_rd_data;
          end
          if (!rd_run_q && !pend_vld_q) begin
            state_q   <= ST_FILL;
            wr_en_q   <= 1'b1;
            wr_addr_q <= FILL_BASE;
            wr_data_q <= BLANK_CELL;
          end
        end

        ST_FILL, ST_CLEAR: begin
          if (wr_addr_q == LAST_ADDR) begin
            wr_en_q <= 1'b0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            wr_addr_q <= wr_addr_q + 12'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign char_ready  = (state_q == ST_IDLE) && !clear_req;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rd_addr_q;
  assign cursor_col  = cur_col;
  assign cursor_row  = cur_row;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: expected RAM writes are queued at stimulus time, a monitor pops and compares.
// The read port returns {4'hA, address} so every scroll write-back value is known in advance.
module tb_vga_text_writer;

  logic        pixel_clk = 1'b0;
  logic        data_reset;
  logic [7:0]  char_in;
  logic [7:0]  attr_in;
  logic        char_valid;
  logic        char_ready;
  logic        clear_req;
  logic [11:0] ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic        ram_wr_en;
  logic [11:0] ram_rd_addr;
  logic [15:0] ram_rd_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [27:0] exp_q[$];
  logic [27:0] exp_w;

  vga_text_writer dut (
    .pixel_clk  (pixel_clk),
    .data_reset (data_reset),
    .char_in    (char_in),
    .attr_in    (attr_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .clear_req  (clear_req),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_wr_en  (ram_wr_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) ram_rd_data <= {4'hA, ram_rd_addr};

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge pixel_clk) begin
    if (ram_wr_en !== 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got en=%b addr=%0d data=%h, required no write",
                 ram_wr_en, ram_wr_addr, ram_wr_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({ram_wr_addr, ram_wr_data} !== exp_w) begin
          bad++;
          $display("FAIL wr_seq: got addr=%0d data=%h, required addr=%0d data=%h",
                   ram_wr_addr, ram_wr_data, exp_w[27:16], exp_w[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_cur(input string name, input int row, input int col);
    chk({name, "_row"}, 32'(cursor_row), 32'(row));
    chk({name, "_col"}, 32'(cursor_col), 32'(col));
  endtask

  task automatic push(input int addr, input logic [15:0] data);
    exp_q.push_back({12'(addr), data});
  endtask

  task automatic send_char(input logic [7:0] c, input logic [7:0] a);
    int n = 0;
    @(negedge pixel_clk);
    while (char_ready !== 1'b1 && n < 5000) begin
      @(negedge pixel_clk);
      n++;
    end
    if (char_ready !== 1'b1) chk("send_timeout", 32'(char_ready), 32'd1);
    char_in    = c;
    attr_in    = a;
    char_valid = 1'b1;
    @(posedge pixel_clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge pixel_clk);
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge pixel_clk);
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic lf_n(input int n);
    for (int i = 0; i < n; i++) begin
      send_char(8'h0A, 8'h07);
      wait_idle();
    end
  endtask

  task automatic push_scroll();
    for (int a = 0; a < 1920; a++) push(a, {4'hA, 12'(a + 80)});
    for (int a = 1920; a < 2000; a++) push(a, 16'h0720);
  endtask

  initial begin
    data_reset = 1'b1;
    char_in    = 8'h00;
    attr_in    = 8'h00;
    char_valid = 1'b0;
    clear_req  = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1 data_reset = 1'b0;
    @(negedge pixel_clk);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(ram_wr_data), 32'd0);
    chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(char_ready), 32'd1);
    chk_cur("rst", 0, 0);

    // First glyph: single write one cycle after acceptance.
    push(0, 16'h0741);
    send_char(8'h41, 8'h07);
    @(negedge pixel_clk);
    chk("a_wr_en_next", 32'(ram_wr_en), 32'd1);
    chk("a_busy", 32'(busy), 32'd1);
    @(negedge pixel_clk);
    chk("a_wr_en_done", 32'(ram_wr_en), 32'd0);
    chk("a_ready", 32'(char_ready), 32'd1);
    chk_cur("a", 0, 1);

    // CR, BS at home, BS across a row boundary.
    send_char(8'h0D, 8'h07);
    chk_cur("cr0", 0, 0);
    send_char(8'h08, 8'h07);
    chk_cur("bs_home", 0, 0);
    lf_n(1);
    send_char(8'h08, 8'h07);
    chk_cur("bs_wrap", 0, 79);
    lf_n(3);
    send_char(8'h08, 8'h07);
    chk_cur("bs_r3", 2, 79);

    // Glyph at end of row wraps without scrolling.
    push(239, 16'h1E42);
    send_char(8'h42, 8'h1E);
    wait_idle();
    chk_cur("eol", 3, 0);

    for (int i = 0; i < 40; i++) push(240 + i, {8'h4F, 8'(8'h30 + i % 10)});
    for (int i = 0; i < 40; i++) begin
      send_char(8'(8'h30 + i % 10), 8'h4F);
      wait_idle();
    end
    chk_cur("c40", 3, 40);
    send_char(8'h0D, 8'h07);
    chk_cur("cr40", 3, 0);

`ifdef VGA_TEXT_WRITER_TAB_EN
    for (int i = 0; i < 3; i++) push(240 + i, {8'h07, 8'(8'h61 + i)});
    for (int i = 0; i < 3; i++) begin
      send_char(8'(8'h61 + i), 8'h07);
      wait_idle();
    end
    for (int a = 243; a < 248; a++) push(a, 16'h1720);
    send_char(8'h09, 8'h17);
    wait_idle();
    chk_cur("tab", 3, 8);
`else
    push(240, 16'h1709);
    send_char(8'h09, 8'h17);
    wait_idle();
    chk_cur("tab_glyph", 3, 1);
`endif

    // Scroll triggered by LF on the last row, cursor at column 5.
    lf_n(21);
    chk_cur("row24", 24, 0);
    for (int i = 0; i < 5; i++) push(1920 + i, {8'h2A, 8'(8'h50 + i)});
    for (int i = 0; i < 5; i++) begin
      send_char(8'(8'h50 + i), 8'h2A);
      wait_idle();
    end
    chk_cur("r24c5", 24, 5);
    push_scroll();
    send_char(8'h0A, 8'h07);
    @(negedge pixel_clk);
    chk("scroll_ready_low", 32'(char_ready), 32'd0);
    wait_idle();
    chk_cur("scroll", 24, 0);
    chk("scroll_q_empty", 32'(exp_q.size()), 32'd0);

    // clear_req beats a simultaneous char; the char is held until the clear completes.
    @(negedge pixel_clk);
    for (int a = 0; a < 2000; a++) push(a, 16'h0720);
    push(0, 16'h0743);
    clear_req  = 1'b1;
    char_valid = 1'b1;
    char_in    = 8'h43;
    attr_in    = 8'h07;
    #1 chk("clr_ready_low", 32'(char_ready), 32'd0);
    @(posedge pixel_clk);
    #1 clear_req = 1'b0;
    @(negedge pixel_clk);
    chk("clr_busy", 32'(busy), 32'd1);
    chk_cur("clr_home", 0, 0);
    begin
      int n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
        @(negedge pixel_clk);
        n++;
      end
      if (char_ready !== 1'b1) chk("clr_timeout", 32'(char_ready), 32'd1);
    end
    @(posedge pixel_clk);
    #1 char_valid = 1'b0;
    wait_idle();
    chk_cur("clr_held", 0, 1);
    chk("clr_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a scroll aborts immediately.
    lf_n(24);
    push_scroll();
    send_char(8'h0A, 8'h07);
    repeat (50) @(negedge pixel_clk);
    data_reset = 1'b1;
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    chk("mid_rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("mid_rst_ready", 32'(char_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk_cur("mid_rst", 0, 0);
    exp_q.delete();
    data_reset = 1'b0;
    repeat (10) @(negedge pixel_clk);
    chk("post_rst_idle", 32'(ram_wr_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
